// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: access-size codes and FSM state encodings shared with the MEM stage
package dmem_responder_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, RESP = 2'b10} state_e;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte enables, store-lane replication and load extraction/extension.
// DMEM_MISALIGN_CHECK_EN enables flagging of misaligned HALF/WORD accesses.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wdata_lane_o,
  output logic [31:0] rdata_ext_o,
  output logic        misaligned_o
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rword_i[{off_i, 3'b000} +: 8];
  // Without the check, HALF ignores off[0] and WORD ignores the offset entirely
  assign h = off_i[1] ? rword_i[31:16] : rword_i[15:0];
  assign byte_en_o = size_i == SZ_BYTE ? 4'b0001 << off_i :
                     size_i == SZ_HALF ? (off_i[1] ? 4'b1100 : 4'b0011) :
                     size_i == SZ_WORD ? 4'b1111 : 4'b0000;
  assign wdata_lane_o = size_i == SZ_BYTE ? {4{wdata_i[7:0]}} :
                        size_i == SZ_HALF ? {2{wdata_i[15:0]}} : wdata_i;
  assign rdata_ext_o = size_i == SZ_BYTE ? {{24{b[7] & ~uns_i}}, b} :
                       size_i == SZ_HALF ? {{16{h[15] & ~uns_i}}, h} :
                       size_i == SZ_WORD ? rword_i : 32'h0;
`ifdef DMEM_MISALIGN_CHECK_EN
  assign misaligned_o = (size_i == SZ_HALF && off_i[0]) || (size_i == SZ_WORD && off_i != 2'b00);
`else
  assign misaligned_o = 1'b0;
`endif
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder over valid/ready with fixed latency.
// Misalignment faults only when built with DMEM_MISALIGN_CHECK_EN.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
  parameter int          LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [31:0] mem [DEPTH_WORDS];
  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] rel_addr, rword, wdata_lane, rdata_ext;
  logic [AW-1:0] widx;
  logic [3:0]  byte_en;
  logic        misaligned, err, accept;
  assign rel_addr = req_addr - BASE_ADDR;
  assign widx     = rel_addr[AW+1:2];
  assign rword    = mem[widx];
  assign err      = req_addr < BASE_ADDR || rel_addr >= 32'(4 * DEPTH_WORDS) ||
                    req_size == 2'b11 || misaligned;
  assign accept   = req_valid && state_q == IDLE;
  dmem_lane_align u_align (
    .size_i       (req_size),
    .off_i        (req_addr[1:0]),
    .uns_i        (req_unsigned),
    .wdata_i      (req_wdata),
    .rword_i      (rword),
    .byte_en_o    (byte_en),
    .wdata_lane_o (wdata_lane),
    .rdata_ext_o  (rdata_ext),
    .misaligned_o (misaligned)
  );
  // Array has no reset: contents survive rst_n
  always_ff @(posedge clk)
    if (accept && req_we && !err)
      for (int i = 0; i < 4; i++)
        if (byte_en[i]) mem[widx][8*i +: 8] <= wdata_lane[8*i +: 8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          state_q <= LATENCY == 1 ? RESP : BUSY;
          cnt_q   <= 4'(LATENCY - 2);
          rdata_q <= (err || req_we) ? 32'h0 : rdata_ext;
          err_q   <= err;
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'h1;
          if (cnt_q == 4'h0) state_q <= RESP;
        end
        RESP: if (rsp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
endmodule
